id_counter_param: RTL and testbench
===================================

# id_counter_param

Parametrised increment/decrement (ID) counter for the DPLL loop. It sits between the K-counter carry/borrow outputs and the N-divider. It divides `clk` by `DIV` to produce the recovered clock. Each carry (inc) shortens one output period by one `clk` cycle, and each borrow (dec) lengthens one by one cycle. Unlike the previous generation, corrections arriving faster than the output period are queued in a saturating signed pending counter instead of being lost, and all outputs are glitch-free flop outputs rather than clock-gated.

## Interface
- `DIV`, 4: nominal division ratio; legal range ≥ 3, so `DIV-1` ≥ 2.
- `PEND_W`, 4: pending-counter width, signed; `PMAX` = 2^(PEND_W-1) − 1, legal range −PMAX..+PMAX.
- `SYNC_STAGES`, 2: synchroniser depth on `inc_in`/`dec_in`; 0 means the inputs are already synchronous to `clk`.

- `clk`  in  1  reset: reset, asynchronous, active-low; clock: clk. Rising edge used throughout.
- `reset`  in  1  asynchronous, active-low; returns all state to reset values.
- `en`  in  1  run enable for the output divider.
- `inc_in`  in  1  K-counter carry, asynchronous level; each rising edge is one increment request.
- `dec_in`  in  1  K-counter borrow, asynchronous level; each rising edge is one decrement request.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `id_out`  out  1  one-cycle pulse per output period.
- `id_clk`  out  1  square-wave version of the output period.
- `pend`  out  PEND_W  signed pending correction count.
- `inc_applied`  out  1  strobe: the period that starts next is shortened.
- `dec_applied`  out  1  strobe: the period that starts next is lengthened.
- `ovf`  out  1  sticky flag: a request was dropped at saturation.

## Operation
- **Input conditioning.** Each input passes through `SYNC_STAGES` flops, then a rising-edge detector that produces `inc_evt`/`dec_evt`. All sync and history flops reset to 1, so an input already high at reset release produces no event.
- **Pending counter.** The update uses `d = inc_evt − dec_evt − c`, where `c` is the consumption at a terminal cycle (+1, −1 or 0).
  - When both events occur in the same cycle, they cancel.
  - If `pend + d` would exceed +PMAX or fall below −PMAX, the event is dropped. The consumption is still applied, and `ovf` is set.
  - `clr_ovf` clears `ovf`; a set in the same cycle wins.
- **Divider state.** Phase counter `ph` runs 0..`last`, where `last` is a register.
- **Terminal cycle** (`ph == last` and `en`): `ph` → 0, and the next `last` is chosen from the current `pend`:
  - `pend` > 0 → `last` = `DIV-2`; `inc_applied` = 1; `c` = +1.
  - `pend` < 0 → `last` = `DIV`; `dec_applied` = 1; `c` = −1.
  - `pend` = 0 → `last` = `DIV-1`; `c` = 0.
- **Correction rate.** At most one correction is applied per output period.
- **Output decode.** Both outputs are registered from next-state values:
  - `id_out` = 1 while `ph` = 0 and `en` is active.
  - `id_clk` = 1 while `ph` < ceil((`last`+1)/2).
- **`en` = 0.** `ph` is held at 0 and `last` at `DIV-1`. `id_out`, `id_clk` and the strobes are 0. `pend` keeps accumulating events.
- **`en` rising.** The first period starts at `ph` = 0 with nominal length, and the first `pend` is consumed at its terminal cycle.

## Timing
- **Reset values:**
  - `ph` = 0, `last` = `DIV-1`, `pend` = 0.
  - `id_out`, `id_clk`, `inc_applied`, `dec_applied`, `ovf` all 0.
  - Sync and history flops = 1.
- **Input latency.** A rising edge of `inc_in` sampled at edge k updates `pend` at edge k+`SYNC_STAGES`.
- **Enable latency.** `en` sampled high at edge k gives `id_out` = 1 in the cycle after edge k.
- **Period lengths.** Output period = `DIV`−1, `DIV` or `DIV`+1 cycles. Pulse spacing changes only at terminal cycles.
- **Strobes.** `inc_applied`/`dec_applied` are high for exactly the terminal cycle, one cycle before the affected `id_out` pulse.
- **Reset mid-period.** All outputs drop immediately (asynchronous reset). Queued corrections are discarded.

## Structure
- **Package `idc_pkg`:**
  - `adj_t` enum {ADJ_NONE, ADJ_INC, ADJ_DEC}.
  - Width function for `ph`/`last`, i.e. clog2(`DIV`+1).
  - Saturating signed add function parameterised by `PEND_W`.
- **Sub-module `edge_sync`:** synchroniser plus rising-edge detector, parameter `STAGES`, reset-to-1. Instantiated twice, once for inc and once for dec.

## Test plan
1. Reset, `en`=1, no events, `DIV`=4 → `id_out` pulses every 4 cycles; `id_clk` runs 2 high / 2 low; `pend`=0.
2. One `inc_in` edge mid-period → `pend`=1 two cycles later. At the next terminal cycle, `inc_applied`=1 and `pend`=0. That period is 3 cycles (`id_clk` 2 high / 1 low), then periods return to 4.
3. Three `dec_in` edges within one period → `pend`=−3. The next three periods are 5 cycles each, with `dec_applied` once per period, then 4.
4. `inc_in` and `dec_in` rising on the same edge → `pend` unchanged, all periods 4, `ovf`=0.
5. `en`=0 and nine `inc_in` edges with `PEND_W`=4 → `pend`=7 and `ovf`=1. Then `clr_ovf` → `ovf`=0. Then `en`=1 → seven 3-cycle periods, then 4-cycle periods.
6. `pend`=3 with `ph`=2, assert `reset` → all outputs 0 immediately and `pend`=0. After release with `en`=1, the first `id_out` occurs one cycle after `en` is sampled, and periods are 4.

Source files
------------

// File: rtl/id_counter_param_pkg.sv
// Shared types and helpers for the DPLL increment/decrement counter.
package idc_pkg;

  typedef enum logic [1:0] {ADJ_NONE, ADJ_INC, ADJ_DEC} adj_t;

  function automatic int ph_width(input int div);
    return $clog2(div + 1);
  endfunction

  // Adds delta to base within +/-(2^(pend_w-1)-1); an out-of-range result keeps base.
  function automatic int sat_add(input int base, input int delta, input int pend_w,
                                 output logic ovf);
    int pmax;
    int sum;
    pmax = (1 << (pend_w - 1)) - 1;
    sum  = base + delta;
    if (sum > pmax || sum < -pmax) begin
      ovf = 1'b1;
      return base;
    end
    ovf = 1'b0;
    return sum;
  endfunction

endpackage

// File: rtl/id_counter_param_if.sv
// Control inputs and recovered-clock outputs of the ID counter.
interface id_counter_param_if #(parameter int PEND_W = 4);
  logic                     en;
  logic                     inc_in;
  logic                     dec_in;
  logic                     clr_ovf;
  logic                     id_out;
  logic                     id_clk;
  logic signed [PEND_W-1:0] pend;
  logic                     inc_applied;
  logic                     dec_applied;
  logic                     ovf;

  modport master (
    output en, inc_in, dec_in, clr_ovf,
    input  id_out, id_clk, pend, inc_applied, dec_applied, ovf
  );

  modport slave (
    input  en, inc_in, dec_in, clr_ovf,
    output id_out, id_clk, pend, inc_applied, dec_applied, ovf
  );
endinterface

// File: rtl/id_counter_param_edge_sync.sv
// Synchroniser plus rising-edge detector; every flop resets high so a level
// already high at reset release is not seen as an edge. Event lags input by STAGES edges.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic evt
);
  logic s;
  logic hist;

  if (STAGES == 0) begin : g_bypass
    assign s = d;
  end else begin : g_sync
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr <= '1;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    end
    assign s = sr[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 1'b1;
    else        hist <= s;
  end

  assign evt = s & ~hist;
endmodule

// File: rtl/id_counter_param.sv
// Divides clk by DIV, shortening/lengthening one period per queued carry/borrow.
// Outputs are registered from next-state; corrections queue in a saturating pending count.
module id_counter_param
  import idc_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int PEND_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  id_counter_param_if.slave bus
);
  localparam int W = ph_width(DIV);
  localparam logic [W-1:0] LAST_NOM   = W'(DIV - 1);
  localparam logic [W-1:0] LAST_SHORT = W'(DIV - 2);
  localparam logic [W-1:0] LAST_LONG  = W'(DIV);

  logic [W-1:0]             ph, last, ph_n, last_n;
  logic signed [PEND_W-1:0] pend, pend_n;
  logic                     run, inc_evt, dec_evt, sat_ovf;
  logic                     id_out_q, id_clk_q, inc_q, dec_q, ovf_q;
  adj_t                     adj_n;
  int                       c, sum;

  edge_sync #(.STAGES(SYNC_STAGES)) u_inc_sync (
    .clk(clk), .reset(reset), .d(bus.inc_in), .evt(inc_evt)
  );
  edge_sync #(.STAGES(SYNC_STAGES)) u_dec_sync (
    .clk(clk), .reset(reset), .d(bus.dec_in), .evt(dec_evt)
  );

  always_comb begin
    c      = 0;
    ph_n   = '0;
    last_n = LAST_NOM;
    // The first cycle after en rises restarts the divider at ph=0 with nominal length.
    if (bus.en && run) begin
      if (ph == last) begin
        // The strobe registered for this terminal cycle already encodes sign(pend).
        if (inc_q) begin
          last_n = LAST_SHORT;
          c      = 1;
        end else if (dec_q) begin
          last_n = LAST_LONG;
          c      = -1;
        end
      end else begin
        ph_n   = ph + 1'b1;
        last_n = last;
      end
    end

    sum    = sat_add(int'(pend) - c, int'(inc_evt) - int'(dec_evt), PEND_W, sat_ovf);
    pend_n = PEND_W'(sum);

    adj_n = ADJ_NONE;
    if (bus.en && (ph_n == last_n)) begin
      if (pend_n > 0)      adj_n = ADJ_INC;
      else if (pend_n < 0) adj_n = ADJ_DEC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph       <= '0;
      last     <= LAST_NOM;
      run      <= 1'b0;
      pend     <= '0;
      id_out_q <= 1'b0;
      id_clk_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ph       <= ph_n;
      last     <= last_n;
      run      <= bus.en;
      pend     <= pend_n;
      id_out_q <= bus.en && (ph_n == '0);
      id_clk_q <= bus.en && (int'(ph_n) < (int'(last_n) + 2) / 2);
      inc_q    <= (adj_n == ADJ_INC);
      dec_q    <= (adj_n == ADJ_DEC);
      ovf_q    <= sat_ovf | (ovf_q & ~bus.clr_ovf);
    end
  end

  assign bus.id_out      = id_out_q;
  assign bus.id_clk      = id_clk_q;
  assign bus.pend        = pend;
  assign bus.inc_applied = inc_q;
  assign bus.dec_applied = dec_q;
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_id_counter_param.sv
// Bench for id_counter_param: fixed vector table, directed corner sequences, random traffic vs a period-level model.
module tb_id_counter_param;
  localparam int DIV  = 4;
  localparam int PW   = 4;
  localparam int S    = 2;
  localparam int PMAX = (1 << (PW - 1)) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_counter_param_if #(.PEND_W(PW)) bus ();

  id_counter_param #(.DIV(DIV), .PEND_W(PW), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the current period, its length, queued corrections.
  int m_pos, m_len, m_pend;
  bit m_run, m_ovf;
  bit qi[S+2];
  bit qd[S+2];
  bit e_id_out, e_id_clk, e_inc, e_dec;

  task automatic model_reset();
    m_pos = 0; m_len = DIV; m_pend = 0; m_run = 0; m_ovf = 0;
    for (int i = 0; i < S + 2; i++) begin qi[i] = 1; qd[i] = 1; end
    e_id_out = 0; e_id_clk = 0; e_inc = 0; e_dec = 0;
  endtask

  task automatic model_edge(input bit en, input bit inc, input bit dec, input bit clr);
    int ie, de, sgn, tmp, d;
    bit term, set;
    for (int i = S + 1; i > 0; i--) begin qi[i] = qi[i-1]; qd[i] = qd[i-1]; end
    qi[0] = inc; qd[0] = dec;
    ie = (qi[S] && !qi[S+1]) ? 1 : 0;
    de = (qd[S] && !qd[S+1]) ? 1 : 0;
    term = m_run && en && (m_pos == m_len - 1);
    sgn = 0;
    if (term) sgn = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
    tmp = m_pend - sgn;
    d = ie - de;
    set = 0;
    if (d != 0) begin
      if (tmp + d > PMAX || tmp + d < -PMAX) set = 1;
      else tmp = tmp + d;
    end
    m_pend = tmp;
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (!en) begin
      m_pos = 0; m_len = DIV; m_run = 0;
    end else if (!m_run) begin
      m_pos = 0; m_len = DIV; m_run = 1;
    end else if (term) begin
      m_pos = 0; m_len = DIV - sgn;
    end else begin
      m_pos++;
    end
    e_id_out = en && (m_pos == 0);
    e_id_clk = en && (m_pos < (m_len + 1) / 2);
    e_inc    = en && (m_pos == m_len - 1) && (m_pend > 0);
    e_dec    = en && (m_pos == m_len - 1) && (m_pend < 0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [4:0] got, exp;
    got = {bus.id_out, bus.id_clk, bus.inc_applied, bus.dec_applied, bus.ovf};
    exp = {e_id_out, e_id_clk, e_inc, e_dec, m_ovf};
    vectors++;
    if (got !== exp || int'(bus.pend) != m_pend) begin
      miscompares++;
      $display("FAIL %s @%0t: out/clk/inc/dec/ovf got %b expected %b, pend got %0d expected %0d",
               name, $time, got, exp, int'(bus.pend), m_pend);
    end
  endtask

  task automatic step(input string name, input bit en, input bit inc, input bit dec, input bit clr);
    @(negedge clk);
    bus.en = en; bus.inc_in = inc; bus.dec_in = dec; bus.clr_ovf = clr;
    @(posedge clk);
    model_edge(en, inc, dec, clr);
    #1;
    check_model(name);
  endtask

  typedef struct {
    bit en, inc, dec;
    bit id_out, id_clk, inc_a, dec_a;
    int pend;
  } vec_t;

  vec_t tbl[16];
  int   n_inc, n_dec;
  bit   r_en, r_inc, r_dec;

  initial begin
    // en inc dec | id_out id_clk inc_a dec_a pend
    tbl = '{
      '{1,0,0, 1,1,0,0, 0}, '{1,0,0, 0,1,0,0, 0}, '{1,0,0, 0,0,0,0, 0}, '{1,0,0, 0,0,0,0, 0},
      '{1,1,0, 1,1,0,0, 0}, '{1,1,0, 0,1,0,0, 0}, '{1,1,0, 0,0,0,0, 1}, '{1,0,0, 0,0,1,0, 1},
      '{1,0,0, 1,1,0,0, 0}, '{1,0,0, 0,1,0,0, 0}, '{1,0,0, 0,0,0,0, 0}, '{1,0,0, 1,1,0,0, 0},
      '{1,0,0, 0,1,0,0, 0}, '{1,0,0, 0,0,0,0, 0}, '{1,0,0, 0,0,0,0, 0}, '{1,0,0, 1,1,0,0, 0}
    };

    bus.en = 0; bus.inc_in = 0; bus.dec_in = 0; bus.clr_ovf = 0;
    model_reset();
    #1;
    chk("reset_outputs", int'({bus.id_out, bus.id_clk, bus.inc_applied, bus.dec_applied, bus.ovf}), 0);
    chk("reset_pend", int'(bus.pend), 0);
    #20;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) step("idle", 0, 0, 0, 0);

    // Nominal periods, then one carry shortening a single period.
    for (int i = 0; i < 16; i++) begin
      step("tbl_model", tbl[i].en, tbl[i].inc, tbl[i].dec, 0);
      chk($sformatf("tbl%0d_outs", i),
          int'({bus.id_out, bus.id_clk, bus.inc_applied, bus.dec_applied}),
          int'({tbl[i].id_out, tbl[i].id_clk, tbl[i].inc_a, tbl[i].dec_a}));
      chk($sformatf("tbl%0d_pend", i), int'(bus.pend), tbl[i].pend);
    end

    // Three borrows queued while idle, then three long periods.
    for (int i = 0; i < 6; i++) step("dec_queue", 0, 0, (i % 2) == 0, 0);
    for (int i = 0; i < 3; i++) step("dec_settle", 0, 0, 0, 0);
    chk("dec_pend", int'(bus.pend), -3);
    n_dec = 0;
    for (int i = 0; i < 27; i++) begin
      step("dec_run", 1, 0, 0, 0);
      if (bus.dec_applied) n_dec++;
    end
    chk("dec_strobes", n_dec, 3);

    // Simultaneous carry and borrow cancel.
    for (int i = 0; i < 12; i++) step("cancel", 1, (i % 4) < 2, (i % 4) < 2, 0);
    for (int i = 0; i < 4; i++) step("cancel_tail", 1, 0, 0, 0);
    chk("cancel_pend", int'(bus.pend), 0);
    chk("cancel_ovf", int'(bus.ovf), 0);

    // Saturation: nine carries while idle.
    for (int i = 0; i < 18; i++) step("sat_queue", 0, (i % 2) == 0, 0, 0);
    for (int i = 0; i < 3; i++) step("sat_settle", 0, 0, 0, 0);
    chk("sat_pend", int'(bus.pend), PMAX);
    chk("sat_ovf", int'(bus.ovf), 1);
    step("clr_ovf", 0, 0, 0, 1);
    chk("clr_ovf", int'(bus.ovf), 0);
    n_inc = 0;
    for (int i = 0; i < 33; i++) begin
      step("sat_run", 1, 0, 0, 0);
      if (bus.inc_applied) n_inc++;
    end
    chk("sat_strobes", n_inc, PMAX);
    chk("sat_drained", int'(bus.pend), 0);

    // Reset in the middle of a period with corrections queued.
    for (int i = 0; i < 6; i++) step("rst_queue", 0, (i % 2) == 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rst_settle", 0, 0, 0, 0);
    chk("rst_pend_before", int'(bus.pend), 3);
    for (int i = 0; i < 10; i++) begin
      step("rst_run", 1, 0, 0, 0);
      if (m_pos == 2) break;
    end
    chk("rst_ph_reached", m_pos, 2);
    #2 reset = 1'b0;
    #1;
    chk("rst_outputs", int'({bus.id_out, bus.id_clk, bus.inc_applied, bus.dec_applied, bus.ovf}), 0);
    chk("rst_pend", int'(bus.pend), 0);
    model_reset();
    @(negedge clk); bus.en = 0; reset = 1'b1;
    step("post_rst_idle", 0, 0, 0, 0);
    step("post_rst_first", 1, 0, 0, 0);
    chk("post_rst_id_out", int'(bus.id_out), 1);
    for (int i = 0; i < 12; i++) step("post_rst_run", 1, 0, 0, 0);

    // Random traffic.
    r_en = 1; r_inc = 0; r_dec = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) r_en = ~r_en;
      if ($urandom_range(0, 2) == 0) r_inc = ~r_inc;
      if ($urandom_range(0, 3) == 0) r_dec = ~r_dec;
      step("random", r_en, r_inc, r_dec, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
